// File: rtl/timer_tima_pkg.sv
// Shared constants and types for the TIMA timer block.
package timer_tima_pkg;

  // Register offsets within the FF04-FF07 window (FF04 itself belongs to the divider).
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  // Unused TAC bits read back as ones.
  localparam logic [4:0] TAC_RD_FILL = 5'b11111;

  // Overflow sequencing: counting, one cycle of TIMA=00, one cycle of reload.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_OVF    = 2'd1,
    ST_RELOAD = 2'd2
  } tima_state_e;

  // TAC[1:0] clock select encoding.
  typedef enum logic [1:0] {
    TAC_SEL_4096   = 2'd0,
    TAC_SEL_262144 = 2'd1,
    TAC_SEL_65536  = 2'd2,
    TAC_SEL_16384  = 2'd3
  } tac_sel_e;

  function automatic logic [7:0] tac_readback(input logic [2:0] tac);
    return {TAC_RD_FILL, tac};
  endfunction

endpackage

// File: rtl/timer_tima_if.sv
// CPU-side control strobes for the FF04-FF07 register window.
interface timer_tima_if;
  logic       ff04_ff07;
  logic [1:0] a;
  logic       cpu_wr;
  logic       cpu_rd;

  modport master (output ff04_ff07, output a, output cpu_wr, output cpu_rd);
  modport slave  (input  ff04_ff07, input  a, input  cpu_wr, input  cpu_rd);
endinterface

// File: rtl/timer_tap_edge.sv
// Selects the divider tap named by TAC, gates it with the enable and flags falling edges.
module timer_tap_edge
  import timer_tima_pkg::*;
(
  input  logic     clk,
  input  logic     nreset,
  input  logic     tac_en,
  input  tac_sel_e tac_sel,
  input  logic     div_4096hz,
  input  logic     div_16384hz,
  input  logic     div_65536hz,
  input  logic     div_262144hz,
  output logic     tap_fall
);

  logic sel_div;
  logic tap_d;
  logic tap_q;

  // Tap mux: a disabled timer or a TAC change can drop the tap and count once.
  always_comb begin
    sel_div = 1'b0;
    case (tac_sel)
      TAC_SEL_4096:   sel_div = div_4096hz;
      TAC_SEL_262144: sel_div = div_262144hz;
      TAC_SEL_65536:  sel_div = div_65536hz;
      TAC_SEL_16384:  sel_div = div_16384hz;
      default:        sel_div = 1'b0;
    endcase
    tap_d = tac_en & sel_div;
  end

  // Previous-cycle tap; cleared on reset so the first cycle after release cannot count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) tap_q <= 1'b0;
    else         tap_q <= tap_d;
  end

  assign tap_fall = tap_q & ~tap_d;

endmodule

// File: rtl/timer_tima.sv
// TIMA/TMA/TAC timer: counts divider tap falling edges, reloads from TMA on overflow.
module timer_tima
  import timer_tima_pkg::*;
(
  input  logic         clk,
  input  logic         nreset,
  input  logic         div_4096hz,
  input  logic         div_16384hz,
  input  logic         div_65536hz,
  input  logic         div_262144hz,
  timer_tima_if.slave  bus,
  inout  tri   [7:0]   d,
  output logic         int_timer
);

  tima_state_e state_q, state_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic [7:0]  din;
  logic [7:0]  rd_data;
  logic        tap_fall;
  logic        wr_tima, wr_tma, wr_tac, rd_en;

  assign din     = d;
  assign wr_tima = bus.cpu_wr & bus.ff04_ff07 & (bus.a == REG_TIMA);
  assign wr_tma  = bus.cpu_wr & bus.ff04_ff07 & (bus.a == REG_TMA);
  assign wr_tac  = bus.cpu_wr & bus.ff04_ff07 & (bus.a == REG_TAC);
  assign rd_en   = bus.cpu_rd & bus.ff04_ff07 & (bus.a != 2'd0);

  timer_tap_edge u_tap_edge (
    .clk          (clk),
    .nreset       (nreset),
    .tac_en       (tac_q[2]),
    .tac_sel      (tac_sel_e'(tac_q[1:0])),
    .div_4096hz   (div_4096hz),
    .div_16384hz  (div_16384hz),
    .div_65536hz  (div_65536hz),
    .div_262144hz (div_262144hz),
    .tap_fall     (tap_fall)
  );

  // State register; reset abandons any overflow in progress.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Next state: wrap to 00 enters OVF; a TIMA write in OVF cancels the reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (!wr_tima && tap_fall && (tima_q == 8'hFF)) state_d = ST_OVF;
      ST_OVF:    state_d = wr_tima ? ST_RUN : ST_RELOAD;
      ST_RELOAD: state_d = (tap_fall && (tma_d == 8'hFF)) ? ST_OVF : ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Register updates. TMA is copied into TIMA on leaving OVF so the reload cycle
  // already shows it; during RELOAD TIMA keeps tracking TMA (including a TMA write
  // that cycle), TIMA writes are dropped, and a tap edge counts on top of the value.
  always_comb begin
    tma_d  = wr_tma ? din : tma_q;
    tac_d  = wr_tac ? din[2:0] : tac_q;
    tima_d = tima_q;
    case (state_q)
      ST_RUN: begin
        if (wr_tima)       tima_d = din;
        else if (tap_fall) tima_d = tima_q + 8'd1;
      end
      ST_OVF:    tima_d = wr_tima ? din : tma_d;
      ST_RELOAD: tima_d = tma_d + {7'd0, tap_fall};
      default:   tima_d = tima_q;
    endcase
  end

  // Architectural registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tima_q <= '0;
      tma_q  <= '0;
      tac_q  <= '0;
    end else begin
      tima_q <= tima_d;
      tma_q  <= tma_d;
      tac_q  <= tac_d;
    end
  end

  // Outputs: interrupt during the reload cycle, combinational read mux.
  always_comb begin
    int_timer = (state_q == ST_RELOAD);
    rd_data   = '0;
    case (bus.a)
      REG_TIMA: rd_data = tima_q;
      REG_TMA:  rd_data = tma_q;
      REG_TAC:  rd_data = tac_readback(tac_q);
      default:  rd_data = '0;
    endcase
  end

  assign d = rd_en ? rd_data : 'z;

endmodule
